// File: rtl/gpu_vertex_pkg.sv
// Shared definitions for the vertex fetch path: FSM state encoding and
// geometry helpers that turn attribute/bus parameters into vertex size
// and beat count.
package gpu_vertex_pkg;

  // Batch fetch controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } vbf_state_e;

  // Width of vertex index, count and stride fields.
  localparam int VTX_INDEX_W = 16;

  // Total bits in one assembled vertex.
  function automatic int vtx_bits(input int attr_width, input int attrs_per_vertex);
    return attr_width * attrs_per_vertex;
  endfunction

  // Number of memory beats needed to fetch one vertex.
  function automatic int beats_per_vertex(input int vertex_bits, input int bus_width);
    return vertex_bits / bus_width;
  endfunction

  // True when a vertex is an exact, non-zero number of bus beats.
  function automatic bit beats_exact(input int vertex_bits, input int bus_width);
    return (bus_width > 0) && (vertex_bits >= bus_width) && ((vertex_bits % bus_width) == 0);
  endfunction

endpackage

// File: rtl/vertex_beat_assembler.sv
// Collects BEATS consecutive bus beats into one vertex-wide register.
// Beat k lands in bits [k*BUS_WIDTH +: BUS_WIDTH]. asm_next shows the
// assembly including the beat accepted this cycle, so the parent can
// capture a complete vertex on the same edge the last beat arrives.
module vertex_beat_assembler
  import gpu_vertex_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int BEATS     = 4,
  parameter int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       beat_accept,
  input  logic [BUS_WIDTH-1:0]       beat_data,
  output logic [CNT_W-1:0]           beat_cnt,
  output logic                       last_beat,
  output logic [BEATS*BUS_WIDTH-1:0] asm_data,
  output logic [BEATS*BUS_WIDTH-1:0] asm_next
);

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  // Merge the beat being accepted into a view of the assembly register.
  always_comb begin
    asm_next = asm_data;
    if (beat_accept) begin
      asm_next[int'(beat_cnt) * BUS_WIDTH +: BUS_WIDTH] = beat_data;
    end
  end

  // Beat counter and assembly storage; clear drops any partial vertex.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      asm_data <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (beat_accept) begin
      asm_data <= asm_next;
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vertex_batch_fetch.sv
// Vertex batch fetcher: walks a strided vertex array, reads each vertex
// as BEATS bus beats, and streams assembled vertices through a single
// output buffer.
//
// Handshakes: a memory beat transfers on a clk edge where
// o_mem_req && i_mem_ready (i_mem_rdata valid that cycle); a vertex
// transfers on a clk edge where o_vtx_valid && i_vtx_ready. While a
// request/valid is up and not yet accepted, its address/payload holds.
module vertex_batch_fetch
  import gpu_vertex_pkg::*;
#(
  parameter int ATTR_WIDTH       = 32,
  parameter int ATTRS_PER_VERTEX = 8,
  parameter int ADDR_WIDTH       = 32,
  parameter int BUS_WIDTH        = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic                                 i_abort,
  input  logic [ADDR_WIDTH-1:0]                i_base_addr,
  input  logic [15:0]                          i_first_index,
  input  logic [15:0]                          i_vertex_count,
  input  logic [15:0]                          i_stride_bytes,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_mem_req,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  input  logic                                 i_mem_ready,
  input  logic [BUS_WIDTH-1:0]                 i_mem_rdata,
  output logic                                 o_vtx_valid,
  input  logic                                 i_vtx_ready,
  output logic [ATTR_WIDTH*ATTRS_PER_VERTEX-1:0] o_vertex_data,
  output logic [15:0]                          o_vtx_index,
  output logic                                 o_vtx_last,
  output logic [1:0]                           o_dbg_state
);

  localparam int VTX_BITS  = vtx_bits(ATTR_WIDTH, ATTRS_PER_VERTEX);
  localparam int BEATS     = beats_per_vertex(VTX_BITS, BUS_WIDTH);
  localparam int BUS_BYTES = BUS_WIDTH / 8;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  // A vertex must split into whole bus beats.
  if (!beats_exact(VTX_BITS, BUS_WIDTH)) begin : g_bad_geometry
    $error("vertex_batch_fetch: VTX_BITS must be a non-zero multiple of BUS_WIDTH");
  end

  vbf_state_e             state;
  logic [ADDR_WIDTH-1:0]  base_r;
  logic [ADDR_WIDTH-1:0]  vtx_addr_r;
  logic [15:0]            stride_r;
  logic [15:0]            idx_r;
  logic [15:0]            rem_r;

  logic                   vtx_valid_r;
  logic                   vtx_last_r;
  logic [15:0]            vtx_index_r;
  logic [VTX_BITS-1:0]    vtx_data_r;

  logic                   beat_acc;
  logic                   out_hs;
  logic                   can_load;
  logic                   abort_go;
  logic                   start_go;
  logic                   asm_clear;
  logic                   last_beat;
  logic                   final_vtx;
  logic                   load_fetch;
  logic                   load_hold;
  logic                   load_buf;
  logic [CNT_W-1:0]       beat_cnt;
  logic [VTX_BITS-1:0]    asm_data;
  logic [VTX_BITS-1:0]    asm_next;
  logic [ADDR_WIDTH-1:0]  beat_off;
  logic [15:0]            nxt_idx;
  logic [ADDR_WIDTH-1:0]  nxt_addr;

  // Byte address of a vertex; index*stride is taken mod 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] vertex_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [15:0]           idx,
    input logic [15:0]           stride
  );
    logic [31:0] prod;
    prod = 32'(idx) * 32'(stride);
    return base + ADDR_WIDTH'(prod);
  endfunction

  assign o_mem_req  = (state == ST_FETCH);
  assign beat_acc   = o_mem_req && i_mem_ready;
  assign out_hs     = vtx_valid_r && i_vtx_ready;
  assign can_load   = !vtx_valid_r || i_vtx_ready;
  assign abort_go   = i_abort && (state != ST_IDLE);
  assign start_go   = i_start && (state == ST_IDLE);
  assign asm_clear  = abort_go || start_go;
  assign final_vtx  = (rem_r == 16'd1);

  // Completed vertex goes to the buffer straight from the bus when the
  // buffer is free, or from the held assembly once the buffer drains.
  assign load_fetch = (state == ST_FETCH) && beat_acc && last_beat && can_load;
  assign load_hold  = (state == ST_HOLD) && out_hs;
  assign load_buf   = load_fetch || load_hold;

  assign nxt_idx    = idx_r + 16'd1;
  assign nxt_addr   = vertex_addr(base_r, nxt_idx, stride_r);
  assign beat_off   = ADDR_WIDTH'(beat_cnt) * ADDR_WIDTH'(BUS_BYTES);
  assign o_mem_addr = vtx_addr_r + beat_off;

  assign o_busy        = (state != ST_IDLE);
  assign o_done        = (state == ST_DONE) && !vtx_valid_r;
  assign o_vtx_valid   = vtx_valid_r;
  assign o_vertex_data = vtx_data_r;
  assign o_vtx_index   = vtx_index_r;
  assign o_vtx_last    = vtx_last_r;
  assign o_dbg_state   = state;

  vertex_beat_assembler #(
    .BUS_WIDTH (BUS_WIDTH),
    .BEATS     (BEATS),
    .CNT_W     (CNT_W)
  ) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (asm_clear),
    .beat_accept (beat_acc),
    .beat_data   (i_mem_rdata),
    .beat_cnt    (beat_cnt),
    .last_beat   (last_beat),
    .asm_data    (asm_data),
    .asm_next    (asm_next)
  );

  // Batch sequencing: latch the batch, step through vertices, park in
  // HOLD when the output buffer is full, and finish via DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base_r     <= '0;
      vtx_addr_r <= '0;
      stride_r   <= '0;
      idx_r      <= '0;
      rem_r      <= '0;
    end else if (abort_go) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            base_r     <= i_base_addr;
            stride_r   <= i_stride_bytes;
            idx_r      <= i_first_index;
            rem_r      <= i_vertex_count;
            vtx_addr_r <= vertex_addr(i_base_addr, i_first_index, i_stride_bytes);
            state      <= (i_vertex_count == 16'd0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH, ST_HOLD: begin
          if (state == ST_FETCH && beat_acc && last_beat && !can_load) begin
            state <= ST_HOLD;
          end else if (load_buf) begin
            if (final_vtx) begin
              state <= ST_DONE;
            end else begin
              idx_r      <= nxt_idx;
              rem_r      <= rem_r - 16'd1;
              vtx_addr_r <= nxt_addr;
              state      <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          if (!vtx_valid_r) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output buffer: loads a finished vertex, empties on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vtx_valid_r <= 1'b0;
      vtx_last_r  <= 1'b0;
      vtx_index_r <= '0;
      vtx_data_r  <= '0;
    end else if (abort_go) begin
      vtx_valid_r <= 1'b0;
    end else if (load_buf) begin
      vtx_valid_r <= 1'b1;
      vtx_data_r  <= load_fetch ? asm_next : asm_data;
      vtx_index_r <= idx_r;
      vtx_last_r  <= final_vtx;
    end else if (out_hs) begin
      vtx_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vertex_batch_fetch.sv
// Bench for vertex_batch_fetch with default geometry (4 beats of 64 bits
// per 256-bit vertex). A memory model returns a word derived from the
// beat address; a reference model computes the beat address stream and
// vertex stream straight from the batch parameters.
module tb_vertex_batch_fetch;
  import gpu_vertex_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic         i_abort;
  logic [31:0]  i_base_addr;
  logic [15:0]  i_first_index;
  logic [15:0]  i_vertex_count;
  logic [15:0]  i_stride_bytes;
  logic         o_busy;
  logic         o_done;
  logic         o_mem_req;
  logic [31:0]  o_mem_addr;
  logic         i_mem_ready;
  logic [63:0]  i_mem_rdata;
  logic         o_vtx_valid;
  logic         i_vtx_ready;
  logic [255:0] o_vertex_data;
  logic [15:0]  o_vtx_index;
  logic         o_vtx_last;
  logic [1:0]   o_dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_acc = -1;
  int last_acc = -1;
  int done_seen = 0;
  bit rand_en = 0;
  int mem_pct = 100;
  int vtx_pct = 100;
  logic [31:0] salt = 32'h0;

  logic [31:0]  exp_addr_q[$];
  logic [272:0] exp_vtx_q[$];   // {last, index, data}

  vertex_batch_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_base_addr    (i_base_addr),
    .i_first_index  (i_first_index),
    .i_vertex_count (i_vertex_count),
    .i_stride_bytes (i_stride_bytes),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .i_mem_ready    (i_mem_ready),
    .i_mem_rdata    (i_mem_rdata),
    .o_vtx_valid    (o_vtx_valid),
    .i_vtx_ready    (i_vtx_ready),
    .o_vertex_data  (o_vertex_data),
    .o_vtx_index    (o_vtx_index),
    .o_vtx_last     (o_vtx_last),
    .o_dbg_state    (o_dbg_state)
  );

  // Memory contents as a function of byte address.
  function automatic logic [63:0] mem_word(input logic [31:0] a, input logic [31:0] s);
    return {a ^ s, a + s};
  endfunction

  assign i_mem_rdata = mem_word(o_mem_addr, salt);

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [279:0] obs, input logic [279:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: beat addresses and vertices for a whole batch.
  task automatic model_batch(input logic [31:0] base, input logic [15:0] first,
                             input logic [15:0] count, input logic [15:0] stride);
    for (int n = 0; n < int'(count); n++) begin
      logic [15:0]  idx;
      logic [31:0]  va;
      logic [31:0]  a;
      logic [255:0] d;
      idx = first + 16'(n);
      va  = base + 32'(idx) * 32'(stride);
      for (int k = 0; k < 4; k++) begin
        a = va + 32'(k * 8);
        exp_addr_q.push_back(a);
        d[k*64 +: 64] = mem_word(a, salt);
      end
      exp_vtx_q.push_back({(n == int'(count) - 1), idx, d});
    end
  endtask

  task automatic start_batch(input logic [31:0] base, input logic [15:0] first,
                             input logic [15:0] count, input logic [15:0] stride);
    salt           = $urandom;
    i_base_addr    = base;
    i_first_index  = first;
    i_vertex_count = count;
    i_stride_bytes = stride;
    model_batch(base, first, count, stride);
    first_acc = -1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int  start_cnt;
    bit  got;
    start_cnt = done_seen;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done_seen != start_cnt) begin
        got = 1'b1;
        break;
      end
    end
    check("done_timeout", got, 1'b1);
    check("beats_left", exp_addr_q.size(), 0);
    check("vertices_left", exp_vtx_q.size(), 0);
  endtask

  // Random ready driver, active only in randomized phases.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) begin
        i_mem_ready = ($urandom_range(0, 99) < mem_pct);
        i_vtx_ready = ($urandom_range(0, 99) < vtx_pct);
      end
    end
  end

  // Scoreboard: checks every beat, every vertex handshake, output
  // stability under back-pressure, and the done pulse.
  initial begin
    logic [272:0] prev_out;
    logic [272:0] e;
    bit prev_stall;
    bit prev_abort;
    bit prev_done;
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    prev_done  = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (o_mem_req && i_mem_ready) begin
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          check("beat_expected", exp_addr_q.size() > 0, 1'b1);
          if (exp_addr_q.size() > 0) check("mem_addr", o_mem_addr, exp_addr_q.pop_front());
        end
        if (prev_stall && !prev_abort) begin
          check("stall_valid", o_vtx_valid, 1'b1);
          check("stall_payload", {o_vtx_last, o_vtx_index, o_vertex_data}, prev_out);
        end
        if (o_vtx_valid && i_vtx_ready && !i_abort) begin
          check("vertex_expected", exp_vtx_q.size() > 0, 1'b1);
          if (exp_vtx_q.size() > 0) begin
            e = exp_vtx_q.pop_front();
            check("vtx_data", o_vertex_data, e[255:0]);
            check("vtx_index", o_vtx_index, e[271:256]);
            check("vtx_last", o_vtx_last, e[272]);
          end
        end
        if (o_done) begin
          done_seen++;
          check("done_width", prev_done, 1'b0);
          check("done_drained", exp_vtx_q.size(), 0);
          check("busy_at_done", o_busy, 1'b1);
        end
        prev_done  = o_done;
        prev_stall = o_vtx_valid && !i_vtx_ready;
        prev_abort = i_abort;
        prev_out   = {o_vtx_last, o_vtx_index, o_vertex_data};
      end
    end
  end

  // Directed sequence.
  initial begin
    int d0;
    bit got;
    rst_n = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_base_addr = '0;
    i_first_index = '0;
    i_vertex_count = '0;
    i_stride_bytes = '0;
    i_mem_ready = 1'b0;
    i_vtx_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();

    // Reset values.
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_mem_req", o_mem_req, 1'b0);
    check("rst_vtx_valid", o_vtx_valid, 1'b0);
    check("rst_vtx_last", o_vtx_last, 1'b0);
    check("rst_vtx_index", o_vtx_index, 16'h0);
    check("rst_vertex_data", o_vertex_data, 256'h0);
    check("rst_mem_addr", o_mem_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // Single vertex at default geometry, everything ready.
    i_mem_ready = 1'b1;
    i_vtx_ready = 1'b1;
    start_batch(32'h1000, 16'd2, 16'd1, 16'd32);
    check("first_busy", o_busy, 1'b1);
    check("first_addr", o_mem_addr, 32'h1040);
    wait_done(50);
    check("single_beats_back_to_back", last_acc - first_acc, 3);
    step();

    // Full-throughput run of 4 vertices.
    start_batch($urandom, 16'd10, 16'd4, 16'd48);
    wait_done(100);
    check("throughput", last_acc - first_acc, 15);
    step();

    // Back-pressure: consumer stalls 6 cycles after first valid.
    start_batch($urandom & 32'hFFFF_FF00, 16'd7, 16'd3, 16'd32);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_vtx_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check("bp_first_valid", got, 1'b1);
    i_vtx_ready = 1'b0;
    repeat (6) step();
    check("bp_hold_state", o_dbg_state, ST_HOLD);
    check("bp_hold_no_req", o_mem_req, 1'b0);
    check("bp_valid_held", o_vtx_valid, 1'b1);
    check("bp_index_held", o_vtx_index, 16'd7);
    i_vtx_ready = 1'b1;
    wait_done(100);
    step();

    // Empty batch.
    d0 = done_seen;
    start_batch($urandom, 16'd5, 16'd0, 16'd32);
    check("empty_done", o_done, 1'b1);
    check("empty_busy", o_busy, 1'b1);
    check("empty_no_req", o_mem_req, 1'b0);
    check("empty_no_valid", o_vtx_valid, 1'b0);
    step();
    check("empty_done_drop", o_done, 1'b0);
    check("empty_idle", o_busy, 1'b0);
    check("empty_done_count", done_seen - d0, 1);
    step();

    // Address wraps at 2^32.
    start_batch(32'hFFFF_FFF0, 16'd0, 16'd1, 16'd32);
    check("wrap_addr0", o_mem_addr, 32'hFFFF_FFF0);
    step();
    step();
    check("wrap_addr2", o_mem_addr, 32'h0000_0000);
    wait_done(50);
    step();

    // Abort during a memory stall on beat 2.
    start_batch(32'h0002_0000, 16'd1, 16'd2, 16'd64);
    step();
    step();
    i_mem_ready = 1'b0;
    step();
    check("stall_addr_a", o_mem_addr, exp_addr_q[0]);
    step();
    check("stall_addr_b", o_mem_addr, exp_addr_q[0]);
    d0 = done_seen;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    exp_addr_q.delete();
    exp_vtx_q.delete();
    check("abort_busy", o_busy, 1'b0);
    check("abort_req", o_mem_req, 1'b0);
    check("abort_valid", o_vtx_valid, 1'b0);
    check("abort_state", o_dbg_state, ST_IDLE);
    i_mem_ready = 1'b1;
    repeat (3) step();
    check("abort_no_done", done_seen - d0, 0);
    start_batch(32'h0003_0000, 16'd4, 16'd2, 16'd40);
    wait_done(100);
    step();

    // i_start while busy is ignored.
    rand_en = 1'b1;
    mem_pct = 70;
    vtx_pct = 60;
    start_batch(32'h0004_0000, 16'd3, 16'd3, 16'd32);
    repeat (3) step();
    i_base_addr = 32'h0FF0_0000;
    i_first_index = 16'd99;
    i_vertex_count = 16'd9;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_done(400);
    step();

    // Random batches, including index wrap past 0xFFFF.
    for (int t = 0; t < 8; t++) begin
      mem_pct = $urandom_range(30, 100);
      vtx_pct = $urandom_range(30, 100);
      if (t == 0)
        start_batch($urandom, 16'hFFFE, 16'd4, 16'($urandom_range(1, 65535)));
      else
        start_batch($urandom, 16'($urandom), 16'($urandom_range(1, 5)), 16'($urandom));
      wait_done(1000);
      step();
    end
    rand_en = 1'b0;
    i_mem_ready = 1'b1;
    i_vtx_ready = 1'b1;
    step();

    // Reset in the middle of a batch.
    start_batch(32'h0005_0000, 16'd0, 16'd3, 16'd32);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_done", o_done, 1'b0);
    check("mid_rst_req", o_mem_req, 1'b0);
    check("mid_rst_valid", o_vtx_valid, 1'b0);
    check("mid_rst_last", o_vtx_last, 1'b0);
    check("mid_rst_index", o_vtx_index, 16'h0);
    check("mid_rst_data", o_vertex_data, 256'h0);
    check("mid_rst_addr", o_mem_addr, 32'h0);
    exp_addr_q.delete();
    exp_vtx_q.delete();
    step();
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (5) step();
    check("post_rst_idle", o_busy, 1'b0);
    check("post_rst_no_req", o_mem_req, 1'b0);
    check("post_rst_no_done", done_seen - d0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vertex_batch_fetch.md
VERTEX_BATCH_FETCH -- requirements
Module: vertex_batch_fetch

Interface
REQ-001 SHALL have parameter ATTR_WIDTH, default 32, bits per attribute.
REQ-002 SHALL have parameter ATTRS_PER_VERTEX, default 8, attributes per vertex; VTX_BITS = ATTR_WIDTH*ATTRS_PER_VERTEX.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 SHALL have parameter BUS_WIDTH, default 64, memory data-bus width; VTX_BITS SHALL be an integer multiple of BUS_WIDTH, BEATS = VTX_BITS/BUS_WIDTH, elaboration error otherwise.
REQ-005 Ports: clk input 1 clock; rst_n input 1, asynchronous active-low reset.
REQ-006 i_start in 1, start batch; i_abort in 1, cancel batch.
REQ-007 i_base_addr in ADDR_WIDTH, vertex array base; i_first_index in 16, first vertex index; i_vertex_count in 16, vertices in batch; i_stride_bytes in 16, byte stride between vertices.
REQ-008 o_busy out 1, batch active; o_done out 1, one-cycle batch-complete pulse.
REQ-009 o_mem_req out 1; o_mem_addr out ADDR_WIDTH; i_mem_ready in 1; i_mem_rdata in BUS_WIDTH; beat transfers on a clk edge where o_mem_req && i_mem_ready, data valid that cycle.
REQ-010 o_vtx_valid out 1; i_vtx_ready in 1; o_vertex_data out VTX_BITS; o_vtx_index out 16; o_vtx_last out 1, final vertex of batch.

Function
REQ-011 States IDLE, FETCH, HOLD, DONE.
REQ-012 IDLE: i_start SHALL latch base, first index, count, stride; count==0 -> DONE, else -> FETCH; i_start outside IDLE SHALL be ignored.
REQ-013 Vertex n (0-based in batch) index = (i_first_index+n) mod 2^16; vertex address = base + index*stride, computed mod 2^ADDR_WIDTH.
REQ-014 Beat k address = vertex address + k*(BUS_WIDTH/8), mod 2^ADDR_WIDTH; beats issued k=0..BEATS-1 in order.
REQ-015 o_mem_req SHALL be high in every FETCH cycle; o_mem_addr SHALL hold steady until the beat is accepted.
REQ-016 Beat k SHALL be written to assembly bits [k*BUS_WIDTH +: BUS_WIDTH].
REQ-017 On last-beat acceptance: if output buffer empty or handshaking that same cycle, assembly SHALL move to output buffer next edge, o_vtx_valid high the following cycle; else -> HOLD with o_mem_req low.
REQ-018 HOLD: on output handshake, assembly moves to output buffer; then FETCH next vertex, or DONE-path if none remain.
REQ-019 Output buffer: o_vtx_valid, o_vertex_data, o_vtx_index, o_vtx_last stable while o_vtx_valid && !i_vtx_ready.
REQ-020 After the final vertex's handshake, DONE SHALL assert o_done for exactly one cycle, then IDLE; o_busy high from cycle after i_start until o_done cycle inclusive.
REQ-021 i_abort in any non-IDLE state SHALL next edge force IDLE, clear o_vtx_valid, drop o_mem_req, discard pending beats, no o_done; i_abort wins over any simultaneous handshake.
REQ-022 Maximum throughput: one vertex per BEATS cycles with i_mem_ready and i_vtx_ready held high.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, o_busy=0, o_done=0, o_mem_req=0, o_vtx_valid=0, o_vtx_last=0, o_vtx_index=0, o_vertex_data=0, o_mem_addr=0.
REQ-024 Reset mid-batch SHALL discard all batch state; first activity after release requires new i_start.

Structure
REQ-025 State enum and BEATS/VTX_BITS helper functions SHALL live in shared package gpu_vertex_pkg.
REQ-026 Beat-to-vertex assembly (beat counter, assembly register) SHALL be sub-module vertex_beat_assembler.

Verification
REQ-027 Defaults, base 0x1000, first 2, count 1, stride 32, ready high -> addresses 0x1040,0x1048,0x1050,0x1058 on 4 consecutive cycles; o_vertex_data = beats little-end-first; o_vtx_last=1, o_vtx_index=2; o_done pulse after handshake.
REQ-028 Count 3, i_vtx_ready low 6 cycles after first valid -> vertex 1 fetched then HOLD with o_mem_req low; output data/index stable; vertices 0,1,2 delivered in order, o_vtx_last only on index first+2.
REQ-029 Count 0 -> o_done pulse 1 cycle after start, o_mem_req never high, o_vtx_valid never high.
REQ-030 Base 0xFFFF_FFF0, first 0, count 1, stride 32 -> addresses 0xFFFFFFF0,0xFFFFFFF8,0x00000000,0x00000008.
REQ-031 i_mem_ready stalled 3 cycles on beat 2, i_abort pulsed during stall -> next cycle IDLE, o_mem_req=0, o_vtx_valid=0, no o_done; new i_start then runs normally.
REQ-032 i_start pulsed while busy with differing base -> ignored, addresses follow original base; rst_n low mid-batch -> all outputs per REQ-023 immediately.
